// File: rtl/ddr2_arb_pkg.sv
// Shared constants for the two-port DDR2 controller arbiter: ownership state
// encodings, master port ids and read-burst / write-burst sizing.
package ddr2_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Each read or write command moves two data beats over the controller bus.
  localparam int BEATS_PER_BURST = 2;

  function automatic logic [1:0] own_state(input logic port);
    return port ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/ddr2_arb_tag_fifo.sv
// One-bit-wide synchronous FIFO holding the issuing port id of each
// outstanding read command, with occupancy count and full/empty flags.
module ddr2_arb_tag_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     din,
  output logic                     dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array is not reset; entries are only read once written,
  // so clearing pointers and count is enough and keeps the array in plain flops.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ddr2_arbiter.sv
// Round-robin arbiter sharing one DDR2 controller between two masters, with
// write-beat debt tracking and read-tag steering of returning data.
module ddr2_arbiter
  import ddr2_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_HOLD   = 256,
  parameter int TAG_DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      m0_request_i,
  output logic                      m0_granted_o,
  input  logic                      m0_rd_wr_n_i,
  input  logic                      m0_af_we_i,
  input  logic                      m0_df_we_i,
  input  logic [30:0]               m0_addr_i,
  input  logic [DATA_WIDTH*2-1:0]   m0_data_i,
  input  logic [DATA_WIDTH/4-1:0]   m0_mask_n_i,
  output logic                      m0_af_afull_o,
  output logic                      m0_df_afull_o,
  output logic [DATA_WIDTH*2-1:0]   m0_data_o,
  output logic                      m0_dvalid_o,

  input  logic                      m1_request_i,
  output logic                      m1_granted_o,
  input  logic                      m1_rd_wr_n_i,
  input  logic                      m1_af_we_i,
  input  logic                      m1_df_we_i,
  input  logic [30:0]               m1_addr_i,
  input  logic [DATA_WIDTH*2-1:0]   m1_data_i,
  input  logic [DATA_WIDTH/4-1:0]   m1_mask_n_i,
  output logic                      m1_af_afull_o,
  output logic                      m1_df_afull_o,
  output logic [DATA_WIDTH*2-1:0]   m1_data_o,
  output logic                      m1_dvalid_o,

  output logic                      ddr_rd_wr_n_o,
  output logic                      ddr_af_we_o,
  output logic                      ddr_df_we_o,
  output logic [30:0]               ddr_addr_o,
  output logic [DATA_WIDTH*2-1:0]   ddr_data_o,
  output logic [DATA_WIDTH/4-1:0]   ddr_mask_n_o,
  input  logic                      ddr_af_afull_i,
  input  logic                      ddr_df_afull_i,
  input  logic                      ddr_dvalid_i,
  input  logic                      ddr_phy_rdy_i,
  input  logic [DATA_WIDTH*2-1:0]   ddr_data_i,

  output logic                      arb_error_o
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int CNT_W  = $clog2(TAG_DEPTH) + 1;
  localparam int BEAT_W = (BEATS_PER_BURST > 1) ? $clog2(BEATS_PER_BURST) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0]  AFULL_LEVEL = CNT_W'(TAG_DEPTH - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BEATS_PER_BURST - 1);
  localparam logic [3:0]        DEBT_PER_WR = 4'(BEATS_PER_BURST);

  logic [1:0]        state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic [2:0]        debt_q, debt_d;
  logic [3:0]        debt_sum;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              error_q, error_d;

  logic              clr;
  logic              own0, own1, owner;
  logic              req_own, req_other, release_ok;
  logic              wr_cmd, rd_cmd, nonowner_strobe;
  logic              tag_push, tag_pop, tag_head, tag_full, tag_empty;
  logic [CNT_W-1:0]  tag_count;

  // Losing the PHY is treated exactly like reset, except for the sticky error.
  assign clr  = reset | ~ddr_phy_rdy_i;

  assign own0  = (state_q == ST_OWN0);
  assign own1  = (state_q == ST_OWN1);
  assign owner = own1;

  assign m0_granted_o = own0;
  assign m1_granted_o = own1;

  always_comb begin
    ddr_rd_wr_n_o = 1'b0;
    ddr_af_we_o   = 1'b0;
    ddr_df_we_o   = 1'b0;
    ddr_addr_o    = '0;
    ddr_data_o    = '0;
    ddr_mask_n_o  = '0;
    if (own0) begin
      ddr_rd_wr_n_o = m0_rd_wr_n_i;
      ddr_af_we_o   = m0_af_we_i;
      ddr_df_we_o   = m0_df_we_i;
      ddr_addr_o    = m0_addr_i;
      ddr_data_o    = m0_data_i;
      ddr_mask_n_o  = m0_mask_n_i;
    end else if (own1) begin
      ddr_rd_wr_n_o = m1_rd_wr_n_i;
      ddr_af_we_o   = m1_af_we_i;
      ddr_df_we_o   = m1_df_we_i;
      ddr_addr_o    = m1_addr_i;
      ddr_data_o    = m1_data_i;
      ddr_mask_n_o  = m1_mask_n_i;
    end
  end

  assign wr_cmd = ddr_af_we_o & ~ddr_rd_wr_n_o;
  assign rd_cmd = ddr_af_we_o &  ddr_rd_wr_n_o;
  assign nonowner_strobe = (~own0 & (m0_af_we_i | m0_df_we_i)) |
                           (~own1 & (m1_af_we_i | m1_df_we_i));

  // Debt is evaluated after this cycle's strobes so the final beat releases at once.
  always_comb begin
    debt_sum = {1'b0, debt_q};
    if (wr_cmd) debt_sum = debt_sum + DEBT_PER_WR;
    if (ddr_df_we_o && debt_sum != 4'd0) debt_sum = debt_sum - 4'd1;
    debt_d = (debt_sum > 4'd7) ? 3'd7 : debt_sum[2:0];
  end

  assign req_own    = own1 ? m1_request_i : m0_request_i;
  assign req_other  = own1 ? m0_request_i : m1_request_i;
  assign hold_inc   = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
  assign release_ok = (~req_own | ((hold_inc == HOLD_MAX) & req_other)) & (debt_d == 3'd0);

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    hold_d       = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_request_i && m1_request_i) state_d = own_state(~last_owner_q);
        else if (m0_request_i)            state_d = ST_OWN0;
        else if (m1_request_i)            state_d = ST_OWN1;
      end
      ST_OWN0, ST_OWN1: begin
        hold_d = hold_inc;
        if (release_ok) state_d = req_other ? own_state(~owner) : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) hold_d = '0;
    if (state_d == ST_OWN0)      last_owner_d = PORT0;
    else if (state_d == ST_OWN1) last_owner_d = PORT1;
  end

  assign tag_push = rd_cmd & (~tag_full | tag_pop);
  assign tag_pop  = ddr_dvalid_i & ~tag_empty & (beat_q == LAST_BEAT);

  always_comb begin
    beat_d = beat_q;
    if (ddr_dvalid_i && !tag_empty) beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
  end

  ddr2_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (tag_push),
    .pop   (tag_pop),
    .din   (owner),
    .dout  (tag_head),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  assign m0_data_o   = ddr_data_i;
  assign m1_data_o   = ddr_data_i;
  assign m0_dvalid_o = ddr_dvalid_i & ~tag_empty & (tag_head == PORT0);
  assign m1_dvalid_o = ddr_dvalid_i & ~tag_empty & (tag_head == PORT1);

  assign m0_af_afull_o = ddr_af_afull_i | (tag_count >= AFULL_LEVEL);
  assign m1_af_afull_o = m0_af_afull_o;
  assign m0_df_afull_o = ddr_df_afull_i;
  assign m1_df_afull_o = ddr_df_afull_i;

  assign error_d     = error_q |
                       (ddr_phy_rdy_i & (nonowner_strobe | (ddr_dvalid_i & tag_empty)));
  assign arb_error_o = error_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= ST_IDLE;
      last_owner_q <= PORT1;
      hold_q       <= '0;
      debt_q       <= '0;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hold_q       <= hold_d;
      debt_q       <= debt_d;
      beat_q       <= beat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) error_q <= 1'b0;
    else       error_q <= error_d;
  end

endmodule

// File: tb/tb_ddr2_arbiter.sv
// Self-checking bench for ddr2_arbiter: table-driven arbitration vectors plus
// scoreboarded write-command and read-return sequences.
module tb_ddr2_arbiter;
  import ddr2_arb_pkg::*;

  localparam int DATA_WIDTH = 16;
  localparam int MAX_HOLD   = 8;
  localparam int TAG_DEPTH  = 16;
  localparam int DW = DATA_WIDTH * 2;
  localparam int MW = DATA_WIDTH / 4;

  logic clk, reset;
  logic m0_request_i, m0_granted_o, m0_rd_wr_n_i, m0_af_we_i, m0_df_we_i;
  logic [30:0] m0_addr_i;
  logic [DW-1:0] m0_data_i, m0_data_o;
  logic [MW-1:0] m0_mask_n_i;
  logic m0_af_afull_o, m0_df_afull_o, m0_dvalid_o;
  logic m1_request_i, m1_granted_o, m1_rd_wr_n_i, m1_af_we_i, m1_df_we_i;
  logic [30:0] m1_addr_i;
  logic [DW-1:0] m1_data_i, m1_data_o;
  logic [MW-1:0] m1_mask_n_i;
  logic m1_af_afull_o, m1_df_afull_o, m1_dvalid_o;
  logic ddr_rd_wr_n_o, ddr_af_we_o, ddr_df_we_o;
  logic [30:0] ddr_addr_o;
  logic [DW-1:0] ddr_data_o, ddr_data_i;
  logic [MW-1:0] ddr_mask_n_o;
  logic ddr_af_afull_i, ddr_df_afull_i, ddr_dvalid_i, ddr_phy_rdy_i;
  logic arb_error_o;

  ddr2_arbiter #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_HOLD   (MAX_HOLD),
    .TAG_DEPTH  (TAG_DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .m0_request_i   (m0_request_i),
    .m0_granted_o   (m0_granted_o),
    .m0_rd_wr_n_i   (m0_rd_wr_n_i),
    .m0_af_we_i     (m0_af_we_i),
    .m0_df_we_i     (m0_df_we_i),
    .m0_addr_i      (m0_addr_i),
    .m0_data_i      (m0_data_i),
    .m0_mask_n_i    (m0_mask_n_i),
    .m0_af_afull_o  (m0_af_afull_o),
    .m0_df_afull_o  (m0_df_afull_o),
    .m0_data_o      (m0_data_o),
    .m0_dvalid_o    (m0_dvalid_o),
    .m1_request_i   (m1_request_i),
    .m1_granted_o   (m1_granted_o),
    .m1_rd_wr_n_i   (m1_rd_wr_n_i),
    .m1_af_we_i     (m1_af_we_i),
    .m1_df_we_i     (m1_df_we_i),
    .m1_addr_i      (m1_addr_i),
    .m1_data_i      (m1_data_i),
    .m1_mask_n_i    (m1_mask_n_i),
    .m1_af_afull_o  (m1_af_afull_o),
    .m1_df_afull_o  (m1_df_afull_o),
    .m1_data_o      (m1_data_o),
    .m1_dvalid_o    (m1_dvalid_o),
    .ddr_rd_wr_n_o  (ddr_rd_wr_n_o),
    .ddr_af_we_o    (ddr_af_we_o),
    .ddr_df_we_o    (ddr_df_we_o),
    .ddr_addr_o     (ddr_addr_o),
    .ddr_data_o     (ddr_data_o),
    .ddr_mask_n_o   (ddr_mask_n_o),
    .ddr_af_afull_i (ddr_af_afull_i),
    .ddr_df_afull_i (ddr_df_afull_i),
    .ddr_dvalid_i   (ddr_dvalid_i),
    .ddr_phy_rdy_i  (ddr_phy_rdy_i),
    .ddr_data_i     (ddr_data_i),
    .arb_error_o    (arb_error_o)
  );

  typedef struct packed {
    logic r0;
    logic r1;
    logic g0;
    logic g1;
  } arb_vec_t;

  typedef struct packed {
    logic [30:0]   addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
  } cmd_t;

  arb_vec_t vecs [13];
  cmd_t     cmd_q [$];
  logic     port_q [$];
  cmd_t     cmd_c, cmd_e;
  logic     exp_port;
  logic [DW-1:0] beat_data;
  int checks = 0;
  int failures = 0;
  int hold_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    m0_request_i = 0; m0_rd_wr_n_i = 0; m0_af_we_i = 0; m0_df_we_i = 0;
    m0_addr_i = '0; m0_data_i = '0; m0_mask_n_i = '0;
    m1_request_i = 0; m1_rd_wr_n_i = 0; m1_af_we_i = 0; m1_df_we_i = 0;
    m1_addr_i = '0; m1_data_i = '0; m1_mask_n_i = '0;
    ddr_af_afull_i = 0; ddr_df_afull_i = 0; ddr_dvalid_i = 0;
    ddr_phy_rdy_i = 1; ddr_data_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  initial begin
    // {r0, r1, g0, g1}: requests driven for one cycle, grants expected after the edge
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state and idle output mux
    do_reset();
    m0_addr_i = 31'h1234_5678;
    m0_data_i = 32'hCAFE_F00D;
    m0_mask_n_i = 4'hA;
    settle();
    check("rst_g0", m0_granted_o, 0);
    check("rst_g1", m1_granted_o, 0);
    check("rst_strobes", {ddr_af_we_o, ddr_df_we_o, ddr_rd_wr_n_o}, 0);
    check("rst_idle_addr", ddr_addr_o, 0);
    check("rst_idle_data", ddr_data_o, 0);
    check("rst_idle_mask", ddr_mask_n_o, 0);
    check("rst_dvalid", {m0_dvalid_o, m1_dvalid_o}, 0);
    check("rst_error", arb_error_o, 0);
    check("rst_af_afull", {m0_af_afull_o, m1_af_afull_o}, 0);
    ddr_af_afull_i = 1;
    ddr_df_afull_i = 1;
    settle();
    check("afull_follow_af", {m0_af_afull_o, m1_af_afull_o}, 2'b11);
    check("afull_follow_df", {m0_df_afull_o, m1_df_afull_o}, 2'b11);
    ddr_af_afull_i = 0;
    settle();
    check("afull_follow_af_low", {m0_af_afull_o, m1_af_afull_o}, 2'b00);

    // Arbitration vectors from reset (first tie goes to port 0)
    do_reset();
    for (int i = 0; i < 13; i++) begin
      m0_request_i = vecs[i].r0;
      m1_request_i = vecs[i].r1;
      tick();
      check($sformatf("arb_vec%0d_g0", i), m0_granted_o, vecs[i].g0);
      check($sformatf("arb_vec%0d_g1", i), m1_granted_o, vecs[i].g1);
    end

    // Four m0 writes with two beats each; m1 strobes must be ignored
    do_reset();
    m0_request_i = 1;
    tick();
    check("wr_grant", m0_granted_o, 1);
    check("wr_error_clear", arb_error_o, 0);
    for (int i = 0; i < 4; i++) begin
      cmd_c.addr = 31'h0000_1000 + 31'(i * 64);
      cmd_c.data = DW'($urandom);
      cmd_c.mask = MW'(i + 3);
      m0_af_we_i = 1; m0_rd_wr_n_i = 0;
      m0_addr_i = cmd_c.addr; m0_data_i = cmd_c.data; m0_mask_n_i = cmd_c.mask;
      m1_af_we_i = (i == 1); m1_rd_wr_n_i = 1;
      m1_addr_i = 31'h3ABC_0000; m1_data_i = ~cmd_c.data; m1_mask_n_i = ~cmd_c.mask;
      cmd_q.push_back(cmd_c);
      settle();
      check("wr_cmd_strobe", ddr_af_we_o, 1);
      check("wr_cmd_dir", ddr_rd_wr_n_o, 0);
      if (ddr_af_we_o) begin
        cmd_e = cmd_q.pop_front();
        check($sformatf("wr_cmd%0d_addr", i), ddr_addr_o, cmd_e.addr);
        check($sformatf("wr_cmd%0d_data", i), ddr_data_o, cmd_e.data);
        check($sformatf("wr_cmd%0d_mask", i), ddr_mask_n_o, cmd_e.mask);
      end
      tick();
      m0_af_we_i = 0;
      m1_af_we_i = 0;
      for (int b = 0; b < 2; b++) begin
        beat_data = DW'($urandom);
        m0_df_we_i = 1; m0_data_i = beat_data;
        m1_df_we_i = (i == 2 && b == 0); m1_data_i = ~beat_data;
        settle();
        check("wr_beat_strobe", {ddr_df_we_o, ddr_af_we_o}, 2'b10);
        check($sformatf("wr_cmd%0d_beat%0d_data", i, b), ddr_data_o, beat_data);
        tick();
      end
      m0_df_we_i = 0;
      m1_df_we_i = 0;
    end
    check("wr_sb_drained", cmd_q.size(), 0);
    check("wr_nonowner_error", arb_error_o, 1);
    m0_request_i = 0;
    tick();
    check("wr_release", m0_granted_o, 0);

    // Hold limit: m1 waits from m0's first grant cycle
    do_reset();
    m0_request_i = 1;
    tick();
    hold_cnt = m0_granted_o ? 1 : 0;
    m1_request_i = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (m0_granted_o) hold_cnt++;
      else break;
    end
    check("hold_grant_cycles", hold_cnt, MAX_HOLD);
    check("hold_handover_g1", m1_granted_o, 1);

    // Saturated hold counter pre-empts as soon as the other port asks
    do_reset();
    m0_request_i = 1;
    for (int k = 0; k < MAX_HOLD + 4; k++) tick();
    check("hold_sat_keep", m0_granted_o, 1);
    m1_request_i = 1;
    tick();
    check("hold_sat_preempt_g0", m0_granted_o, 0);
    check("hold_sat_preempt_g1", m1_granted_o, 1);

    // Release deferred until the second write beat
    do_reset();
    m0_request_i = 1;
    tick();
    m0_af_we_i = 1; m0_rd_wr_n_i = 0;
    tick();
    m0_af_we_i = 0; m0_request_i = 0; m0_df_we_i = 1;
    settle();
    check("defer_beat1_grant", m0_granted_o, 1);
    tick();
    m0_df_we_i = 0;
    settle();
    check("defer_gap_grant", m0_granted_o, 1);
    tick();
    m0_df_we_i = 1;
    settle();
    check("defer_beat2_grant", m0_granted_o, 1);
    check("defer_beat2_strobe", ddr_df_we_o, 1);
    tick();
    m0_df_we_i = 0;
    check("defer_released", m0_granted_o, 0);
    check("defer_no_error", arb_error_o, 0);

    // Read tagging: 3 reads from m0, then 2 from m1
    do_reset();
    m0_request_i = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      m0_af_we_i = 1; m0_rd_wr_n_i = 1; m0_addr_i = 31'h200 + 31'(i);
      for (int b = 0; b < BEATS_PER_BURST; b++) port_q.push_back(PORT0);
      tick();
    end
    m0_af_we_i = 0; m0_request_i = 0; m1_request_i = 1;
    tick();
    check("rd_handover_g1", m1_granted_o, 1);
    check("rd_handover_g0", m0_granted_o, 0);
    for (int i = 0; i < 2; i++) begin
      m1_af_we_i = 1; m1_rd_wr_n_i = 1; m1_addr_i = 31'h300 + 31'(i);
      for (int b = 0; b < BEATS_PER_BURST; b++) port_q.push_back(PORT1);
      tick();
    end
    m1_af_we_i = 0;
    settle();
    check("rd_afull_low", m0_af_afull_o, 0);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        ddr_dvalid_i = 0;
        settle();
        check("rd_gap_dvalid", {m0_dvalid_o, m1_dvalid_o}, 0);
        tick();
      end
      beat_data = DW'($urandom);
      ddr_dvalid_i = 1; ddr_data_i = beat_data;
      settle();
      check($sformatf("rd_beat%0d_any", i + 1), m0_dvalid_o | m1_dvalid_o, 1);
      if (m0_dvalid_o | m1_dvalid_o) begin
        exp_port = port_q.pop_front();
        check($sformatf("rd_beat%0d_m0", i + 1), m0_dvalid_o, exp_port == PORT0);
        check($sformatf("rd_beat%0d_m1", i + 1), m1_dvalid_o, exp_port == PORT1);
        check($sformatf("rd_beat%0d_data", i + 1), {m0_data_o, m1_data_o}, {beat_data, beat_data});
      end
      tick();
    end
    ddr_dvalid_i = 0;
    check("rd_sb_drained", port_q.size(), 0);
    check("rd_no_error", arb_error_o, 0);

    // Fill tag FIFO to TAG_DEPTH-1 outstanding reads
    for (int i = 0; i < TAG_DEPTH - 1; i++) begin
      m1_af_we_i = 1; m1_rd_wr_n_i = 1; m1_addr_i = 31'h400 + 31'(i);
      for (int b = 0; b < BEATS_PER_BURST; b++) port_q.push_back(PORT1);
      tick();
      if (i == TAG_DEPTH - 3) begin
        m1_af_we_i = 0;
        settle();
        check("afull_below_level", m0_af_afull_o, 0);
      end
    end
    m1_af_we_i = 0;
    settle();
    check("afull_at_level", {m0_af_afull_o, m1_af_afull_o}, 2'b11);
    for (int b = 0; b < 2; b++) begin
      ddr_dvalid_i = 1;
      settle();
      if (m0_dvalid_o | m1_dvalid_o) begin
        exp_port = port_q.pop_front();
        check($sformatf("afull_drain%0d_m1", b), m1_dvalid_o, exp_port == PORT1);
      end else begin
        check($sformatf("afull_drain%0d_any", b), m0_dvalid_o | m1_dvalid_o, 1);
      end
      tick();
    end
    ddr_dvalid_i = 0;
    settle();
    check("afull_after_pop", m0_af_afull_o, 0);

    // PHY loss mid-burst with reads outstanding and write debt pending
    m1_af_we_i = 1; m1_rd_wr_n_i = 1;
    tick();
    m1_rd_wr_n_i = 0;
    check("phy_pre_afull", m1_af_afull_o, 1);
    tick();
    m1_af_we_i = 0; m1_df_we_i = 1;
    tick();
    m1_df_we_i = 0; ddr_phy_rdy_i = 0;
    port_q.delete();
    tick();
    check("phy_grants", {m0_granted_o, m1_granted_o}, 0);
    check("phy_fifo_cleared_afull", m1_af_afull_o, 0);
    check("phy_strobes", ddr_af_we_o, 0);
    tick();
    check("phy_hold_idle", m1_granted_o, 0);
    ddr_phy_rdy_i = 1;
    tick();
    check("phy_regrant", m1_granted_o, 1);
    m1_request_i = 0;
    tick();
    check("phy_debt_cleared", m1_granted_o, 0);
    check("phy_error_clear", arb_error_o, 0);
    ddr_dvalid_i = 1;
    settle();
    check("stray_dvalid_blocked", {m0_dvalid_o, m1_dvalid_o}, 0);
    tick();
    ddr_dvalid_i = 0;
    check("stray_dvalid_error", arb_error_o, 1);
    ddr_phy_rdy_i = 0;
    tick();
    ddr_phy_rdy_i = 1;
    tick();
    check("error_sticky_phy", arb_error_o, 1);
    do_reset();
    check("error_cleared_reset", arb_error_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
